// File: rtl/multicycle_control_unit.sv
// Control FSM for a multicycle RISC-V style datapath: fetch/decode/execute/memory/writeback
// sequencing, illegal-opcode trap and a retired-instruction counter.
module multicycle_control_unit #(
  parameter int MEM_HANDSHAKE = 1,
  parameter int CNT_W         = 32,
  parameter int SUPPORT_LUI   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             ir_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [2:0]       state,
  output logic             instr_done,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5,
    BAD6   = 3'd6,
    BAD7   = 3'd7
  } state_t;

  localparam logic [4:0] OP_R   = 5'b01100;
  localparam logic [4:0] OP_I   = 5'b00100;
  localparam logic [4:0] OP_LW  = 5'b00000;
  localparam logic [4:0] OP_SW  = 5'b01000;
  localparam logic [4:0] OP_BEQ = 5'b11000;
  localparam logic [4:0] OP_LUI = 5'b01101;

  state_t           state_reg, state_next;
  logic [4:0]       op_q;
  logic             run_q;
  logic             ready;
  logic [CNT_W-1:0] retired_reg;

  assign ready   = (MEM_HANDSHAKE == 0) ? 1'b1 : mem_ready;
  assign state   = state_reg;
  assign retired = retired_reg;

  function automatic logic legal_op(input logic [4:0] op);
    legal_op = (op == OP_R) || (op == OP_I) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || ((SUPPORT_LUI != 0) && (op == OP_LUI));
  endfunction

  // run_q holds every strobe low until the first edge after reset is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= FETCH;
      op_q        <= 5'd0;
      run_q       <= 1'b0;
      retired_reg <= '0;
    end else begin
      run_q     <= 1'b1;
      state_reg <= state_next;
      if (state_reg == DECODE) op_q <= opcode;
      if (instr_done) retired_reg <= retired_reg + 1'b1;
    end
  end

  always_comb begin
    state_next    = state_reg;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    instr_done    = 1'b0;
    illegal       = 1'b0;
    if (run_q) begin
      case (state_reg)
        FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          if (ready) begin
            ir_write   = 1'b1;
            pc_write   = 1'b1;
            state_next = DECODE;
          end
        end
        DECODE: begin
          alu_src_b  = 2'b10;
          state_next = legal_op(opcode) ? EXEC : TRAP;
        end
        EXEC: begin
          alu_src_a  = 2'b01;
          state_next = WB;
          case (op_q)
            OP_R: alu_op = 2'b10;
            OP_I: begin
              alu_src_b = 2'b10;
              alu_op    = 2'b11;
            end
            OP_LW, OP_SW: begin
              alu_src_b  = 2'b10;
              state_next = MEM;
            end
            OP_BEQ: begin
              alu_op        = 2'b01;
              pc_write_cond = 1'b1;
              instr_done    = 1'b1;
              state_next    = FETCH;
            end
            OP_LUI: begin
              alu_src_a = 2'b11;
              alu_src_b = 2'b10;
            end
            default: begin
              alu_src_a  = 2'b00;
              state_next = FETCH;
            end
          endcase
        end
        MEM: begin
          case (op_q)
            OP_LW: begin
              mem_read = 1'b1;
              if (ready) state_next = WB;
            end
            OP_SW: begin
              mem_write = 1'b1;
              if (ready) begin
                instr_done = 1'b1;
                state_next = FETCH;
              end
            end
            default: state_next = FETCH;
          endcase
        end
        WB: begin
          reg_write  = 1'b1;
          mem_to_reg = (op_q == OP_LW);
          instr_done = 1'b1;
          state_next = FETCH;
        end
        TRAP: begin
          illegal    = 1'b1;
          state_next = TRAP;
        end
        default: state_next = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench: default-parameter unit for the main sequences, plus a CNT_W=4,
// no-handshake, no-LUI unit for counter wrap and single-cycle memory states.
module tb_multicycle_control_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, mem_ready;
  logic [4:0] opcode;
  logic       pc_write, pc_write_cond, ir_write, mem_read, mem_write, mem_to_reg, reg_write;
  logic [1:0] alu_src_a, alu_src_b, alu_op;
  logic [2:0] state;
  logic       instr_done, illegal;
  logic [31:0] retired;

  logic       rst4, mem_ready4;
  logic [4:0] opcode4;
  logic       pc_write4, pc_write_cond4, ir_write4, mem_read4, mem_write4, mem_to_reg4, reg_write4;
  logic [1:0] alu_src_a4, alu_src_b4, alu_op4;
  logic [2:0] state4;
  logic       instr_done4, illegal4;
  logic [3:0] retired4;

  multicycle_control_unit dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .state(state), .instr_done(instr_done), .illegal(illegal),
    .retired(retired)
  );

  multicycle_control_unit #(.MEM_HANDSHAKE(0), .CNT_W(4), .SUPPORT_LUI(0)) dut4 (
    .clk(clk), .rst(rst4), .opcode(opcode4), .mem_ready(mem_ready4),
    .pc_write(pc_write4), .pc_write_cond(pc_write_cond4), .ir_write(ir_write4),
    .mem_read(mem_read4), .mem_write(mem_write4), .mem_to_reg(mem_to_reg4),
    .reg_write(reg_write4), .alu_src_a(alu_src_a4), .alu_src_b(alu_src_b4),
    .alu_op(alu_op4), .state(state4), .instr_done(instr_done4), .illegal(illegal4),
    .retired(retired4)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // EXEC expectations: {pc_write_cond, instr_done, alu_src_a, alu_src_b, alu_op}
  logic [4:0] tbl_op   [3] = '{5'b11000, 5'b00100, 5'b01101};
  logic [7:0] tbl_exec [3] = '{8'b1_1_01_00_01, 8'b0_0_01_10_11, 8'b0_0_11_10_00};

  initial begin
    rst = 1'b1; rst4 = 1'b1; opcode = 5'd0; opcode4 = 5'd0;
    mem_ready = 1'b1; mem_ready4 = 1'b0;
    #2;
    check("rst_state", state, 0);
    check("rst_mem_read", mem_read, 0);
    check("rst_retired", retired, 0);
    check("rst_illegal", illegal, 0);
    step; rst = 1'b0; #1;
    check("release_no_fetch", mem_read, 0);
    step;
    check("fetch_resume", mem_read, 1);
    mem_ready = 1'b0; #1;
    check("fetch_stall_ir", {ir_write, mem_read}, 2'b01);
    step;
    check("fetch_stall_state", state, 0);

    // R-type, no wait states
    mem_ready = 1'b1; opcode = 5'b01100; #1;
    check("r_fetch_ctl", {ir_write, pc_write, mem_read, alu_src_a, alu_src_b, alu_op}, 9'b111_00_01_00);
    step; check("r_decode_state", state, 1);
    check("r_decode_ctl", {ir_write, alu_src_a, alu_src_b, alu_op}, 7'b0_00_10_00);
    step; check("r_exec_state", state, 2);
    check("r_exec_ctl", {reg_write, alu_src_a, alu_src_b, alu_op}, 7'b0_01_00_10);
    step; check("r_wb_state", state, 4);
    check("r_wb_ctl", {reg_write, mem_to_reg, instr_done}, 3'b101);
    check("r_wb_retired", retired, 0);
    step; check("r_done_state", state, 0);
    check("r_retired", retired, 1);
    check("r_fetch_no_wr", reg_write, 0);
    $display("txn R-type retired=%0d", retired);

    // LW with three wait cycles in MEM
    opcode = 5'b00000;
    step; step;
    check("lw_exec_ctl", {alu_src_a, alu_src_b, alu_op}, 6'b01_10_00);
    mem_ready = 1'b0;
    step;
    for (int i = 0; i < 3; i++) begin
      check("lw_mem_wait", {state, mem_read}, {3'd3, 1'b1});
      step;
    end
    mem_ready = 1'b1; #1;
    check("lw_mem_last", {state, mem_read}, {3'd3, 1'b1});
    step; check("lw_wb", {state, reg_write, mem_to_reg, instr_done}, {3'd4, 3'b111});
    step; check("lw_retired", retired, 2);
    $display("txn LW retired=%0d", retired);

    // SW
    opcode = 5'b01000;
    step; step;
    check("sw_exec_ctl", {alu_src_a, alu_src_b, alu_op}, 6'b01_10_00);
    step; check("sw_mem", {state, mem_write, mem_read, instr_done}, {3'd3, 3'b101});
    step; check("sw_done", {state, mem_write, instr_done}, {3'd0, 2'b00});
    check("sw_retired", retired, 3);
    $display("txn SW retired=%0d", retired);

    // opcode input changes during EXEC: latched R-type wins
    opcode = 5'b01100;
    step; step;
    opcode = 5'b00000; #1;
    check("latch_exec_aluop", {alu_src_b, alu_op}, 4'b00_10);
    step; check("latch_wb", {state, reg_write, mem_to_reg}, {3'd4, 2'b10});
    step; check("latch_retired", retired, 4);
    $display("txn R-type (opcode changed) retired=%0d", retired);

    for (int k = 0; k < 3; k++) begin
      opcode = tbl_op[k];
      step; step;
      check("tbl_exec_ctl", {pc_write_cond, instr_done, alu_src_a, alu_src_b, alu_op}, tbl_exec[k]);
      if (k != 0) begin
        step; check("tbl_wb_state", state, 4);
      end
      step; check("tbl_fetch_state", state, 0);
      check("tbl_retired", retired, 5 + k);
      $display("txn opcode=%b retired=%0d", tbl_op[k], retired);
    end

    // illegal opcode traps until reset
    opcode = 5'b11111;
    step; step;
    for (int i = 0; i < 10; i++) begin
      check("trap_hold", {state, illegal}, {3'd5, 1'b1});
      step;
    end
    check("trap_retired", retired, 7);
    rst = 1'b1; #1;
    check("trap_rst", {state, illegal}, {3'd0, 1'b0});
    check("trap_rst_retired", retired, 0);
    $display("txn illegal trap cleared");
    step; rst = 1'b0; step;

    // reset asserted while LW waits in MEM
    opcode = 5'b00000;
    step; step;
    mem_ready = 1'b0;
    step; check("abort_mem_state", state, 3);
    rst = 1'b1; #1;
    check("abort_async", {state, reg_write, mem_read}, {3'd0, 2'b00});
    mem_ready = 1'b1;
    step; check("abort_no_wb", {reg_write, instr_done}, 2'b00);
    rst = 1'b0;
    step; check("abort_after", {state, reg_write}, {3'd0, 1'b0});
    check("abort_retired", retired, 0);
    $display("txn LW aborted by reset");

    // narrow counter, no handshake, no LUI
    step; rst4 = 1'b0; step;
    opcode4 = 5'b11000;
    for (int i = 0; i < 16; i++) begin
      step; step; step;
      check("wrap_retired", {28'd0, retired4}, (i + 1) % 16);
    end
    check("wrap_state", state4, 0);
    $display("txn 16 BEQ retired4=%0d", retired4);
    opcode4 = 5'b01000;
    step; step; step;
    check("nh_sw_mem", {state4, mem_write4, instr_done4}, {3'd3, 2'b11});
    step; check("nh_sw_done", {state4, retired4}, {3'd0, 4'd1});
    $display("txn SW no-handshake retired4=%0d", retired4);
    opcode4 = 5'b01101;
    step; step;
    check("nolui_trap", {state4, illegal4}, {3'd5, 1'b1});
    $display("txn LUI unsupported trap");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
